// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller:
// forward-select encoding, shadow-stage control bundle, register-address width.
package hazard_pkg;

    localparam int RA_W = 5;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_EX   = 2'b11
    } fwd_sel_e;

    typedef struct packed {
        logic [RA_W-1:0] rd;
        logic            reg_write;
        logic            mem_read;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            use_rs1;
        logic            use_rs2;
    } stage_ctrl_t;

endpackage

// File: rtl/hazard_fwd_match.sv
// Single source/destination compare: hit when a used rs equals a written rd.
// Ports: rs_i/use_i (reader), rd_i/reg_write_i (writer), hit_o. x0 never hits.
module hazard_fwd_match #(
    parameter int RA_W = hazard_pkg::RA_W
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic            use_i,
    input  logic [RA_W-1:0] rd_i,
    input  logic            reg_write_i,
    output logic            hit_o
);
    import hazard_pkg::*;

    assign hit_o = use_i && reg_write_i &&
                   (rd_i != '0) && (rs_i == rd_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: shadow EX/MEM/WB
// control, operand and branch-compare forward selects, load-use stall, flush.
// Ports: clock, reset (async, active-low), id_* decode fields, pc_redirect_i;
// pc_write_o, if_id_write_o, control_src_o, id_ex_bubble_o, forward_a/b_o,
// fwd_branch_a/b_o; stall_cnt_o/flush_cnt_o only with HAZ_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int RA_W = hazard_pkg::RA_W
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [RA_W-1:0] id_rs1_i,
    input  logic [RA_W-1:0] id_rs2_i,
    input  logic [RA_W-1:0] id_rd_i,
    input  logic            id_use_rs1_i,
    input  logic            id_use_rs2_i,
    input  logic            id_reg_write_i,
    input  logic            id_mem_read_i,
    input  logic            id_is_branch_i,
    input  logic            pc_redirect_i,
    output logic            pc_write_o,
    output logic            if_id_write_o,
    output logic            control_src_o,
    output logic            id_ex_bubble_o,
    output logic [1:0]      forward_a_o,
    output logic [1:0]      forward_b_o,
    output logic [1:0]      fwd_branch_a_o,
`ifdef HAZ_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic [1:0]      fwd_branch_b_o
);
    import hazard_pkg::*;

    stage_ctrl_t id_ctrl;
    stage_ctrl_t ex_d, ex_q;
    stage_ctrl_t mem_q, wb_q;
    logic        id_valid_d, id_valid_q;
    logic        stall;
    logic        br_a, br_b;
    fwd_sel_e    fa, fb, fba, fbb;

    // Hits for EX operands
    logic a_mem, a_wb, b_mem, b_wb;
    // Hits for ID branch compare
    logic ba_ex, ba_mem, ba_wb;
    logic bb_ex, bb_mem, bb_wb;
    // Hits for load-use against EX (any ID reader)
    logic la_ex, lb_ex;

    assign br_a = id_is_branch_i && id_use_rs1_i;
    assign br_b = id_is_branch_i && id_use_rs2_i;

    always_comb begin
        id_ctrl           = '0;
        id_ctrl.rd        = id_rd_i;
        id_ctrl.reg_write = id_reg_write_i;
        id_ctrl.mem_read  = id_mem_read_i;
        id_ctrl.rs1       = id_rs1_i;
        id_ctrl.rs2       = id_rs2_i;
        id_ctrl.use_rs1   = id_use_rs1_i;
        id_ctrl.use_rs2   = id_use_rs2_i;
    end

    hazard_fwd_match #(.RA_W(RA_W)) u_a_mem (
        .rs_i(ex_q.rs1), .use_i(1'b1),
        .rd_i(mem_q.rd), .reg_write_i(mem_q.reg_write), .hit_o(a_mem));
    hazard_fwd_match #(.RA_W(RA_W)) u_a_wb (
        .rs_i(ex_q.rs1), .use_i(1'b1),
        .rd_i(wb_q.rd), .reg_write_i(wb_q.reg_write), .hit_o(a_wb));
    hazard_fwd_match #(.RA_W(RA_W)) u_b_mem (
        .rs_i(ex_q.rs2), .use_i(1'b1),
        .rd_i(mem_q.rd), .reg_write_i(mem_q.reg_write), .hit_o(b_mem));
    hazard_fwd_match #(.RA_W(RA_W)) u_b_wb (
        .rs_i(ex_q.rs2), .use_i(1'b1),
        .rd_i(wb_q.rd), .reg_write_i(wb_q.reg_write), .hit_o(b_wb));

    hazard_fwd_match #(.RA_W(RA_W)) u_ba_ex (
        .rs_i(id_rs1_i), .use_i(br_a),
        .rd_i(ex_q.rd), .reg_write_i(ex_q.reg_write), .hit_o(ba_ex));
    hazard_fwd_match #(.RA_W(RA_W)) u_ba_mem (
        .rs_i(id_rs1_i), .use_i(br_a),
        .rd_i(mem_q.rd), .reg_write_i(mem_q.reg_write), .hit_o(ba_mem));
    hazard_fwd_match #(.RA_W(RA_W)) u_ba_wb (
        .rs_i(id_rs1_i), .use_i(br_a),
        .rd_i(wb_q.rd), .reg_write_i(wb_q.reg_write), .hit_o(ba_wb));
    hazard_fwd_match #(.RA_W(RA_W)) u_bb_ex (
        .rs_i(id_rs2_i), .use_i(br_b),
        .rd_i(ex_q.rd), .reg_write_i(ex_q.reg_write), .hit_o(bb_ex));
    hazard_fwd_match #(.RA_W(RA_W)) u_bb_mem (
        .rs_i(id_rs2_i), .use_i(br_b),
        .rd_i(mem_q.rd), .reg_write_i(mem_q.reg_write), .hit_o(bb_mem));
    hazard_fwd_match #(.RA_W(RA_W)) u_bb_wb (
        .rs_i(id_rs2_i), .use_i(br_b),
        .rd_i(wb_q.rd), .reg_write_i(wb_q.reg_write), .hit_o(bb_wb));

    hazard_fwd_match #(.RA_W(RA_W)) u_la_ex (
        .rs_i(id_rs1_i), .use_i(id_use_rs1_i),
        .rd_i(ex_q.rd), .reg_write_i(ex_q.reg_write), .hit_o(la_ex));
    hazard_fwd_match #(.RA_W(RA_W)) u_lb_ex (
        .rs_i(id_rs2_i), .use_i(id_use_rs2_i),
        .rd_i(ex_q.rd), .reg_write_i(ex_q.reg_write), .hit_o(lb_ex));

    // Nearest producer wins for EX operands.
    always_comb begin
        fa = FWD_NONE;
        fb = FWD_NONE;
        if (a_mem)     fa = FWD_MEM;
        else if (a_wb) fa = FWD_WB;
        if (b_mem)     fb = FWD_MEM;
        else if (b_wb) fb = FWD_WB;
    end

    // Loads in EX/MEM have no data yet; those cases are covered by stall,
    // WB covers load data and the same-cycle regfile write.
    always_comb begin
        fba = FWD_NONE;
        fbb = FWD_NONE;
        if (ba_ex && !ex_q.mem_read)        fba = FWD_EX;
        else if (ba_mem && !mem_q.mem_read) fba = FWD_MEM;
        else if (ba_wb)                     fba = FWD_WB;
        if (bb_ex && !ex_q.mem_read)        fbb = FWD_EX;
        else if (bb_mem && !mem_q.mem_read) fbb = FWD_MEM;
        else if (bb_wb)                     fbb = FWD_WB;
    end

    assign forward_a_o    = fa;
    assign forward_b_o    = fb;
    assign fwd_branch_a_o = fba;
    assign fwd_branch_b_o = fbb;

    always_comb begin
        stall = 1'b0;
        if (id_valid_q) begin
            stall = (ex_q.mem_read && (la_ex || lb_ex)) ||
                    (mem_q.mem_read && (ba_mem || bb_mem));
        end
    end

    // stall implies id_valid_q, so the two arms never overlap.
    always_comb begin
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        id_ex_bubble_o = 1'b0;
        control_src_o  = 1'b0;
        unique case (1'b1)
            stall: begin
                pc_write_o     = 1'b0;
                if_id_write_o  = 1'b0;
                id_ex_bubble_o = 1'b1;
            end
            !id_valid_q: begin
                id_ex_bubble_o = 1'b1;
            end
            default: begin
                control_src_o = id_is_branch_i;
            end
        endcase
    end

    // control_src_o is 0 while stalled, so a stall holds id_valid at 1.
    assign id_valid_d = !(pc_redirect_i && control_src_o);
    assign ex_d       = id_ex_bubble_o ? '0 : id_ctrl;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            id_valid_q <= 1'b0;
        end else begin
            ex_q       <= ex_d;
            mem_q      <= ex_q;
            wb_q       <= mem_q;
            id_valid_q <= id_valid_d;
        end
    end

    // Shadow fields carried down the pipe but not consumed here.
    logic unused_shadow;
    assign unused_shadow = ^{ex_q.use_rs1, ex_q.use_rs2,
                             mem_q.rs1, mem_q.rs2,
                             mem_q.use_rs1, mem_q.use_rs2,
                             wb_q.mem_read, wb_q.rs1, wb_q.rs2,
                             wb_q.use_rs1, wb_q.use_rs2};

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic             flush;

    assign flush = pc_redirect_i && control_src_o;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: forwarding, load-use stalls,
// branch forwarding, flush, x0 handling and reset during a stall.
module tb_hazard_ctrl;

    logic       clock;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       id_reg_write, id_mem_read, id_is_branch;
    logic       pc_redirect;
    logic       pc_write, if_id_write, control_src, id_ex_bubble;
    logic [1:0] forward_a, forward_b, fwd_branch_a, fwd_branch_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] s0, f0;
`endif

    int checks = 0;
    int errors = 0;

    hazard_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .id_rd_i        (id_rd),
        .id_use_rs1_i   (id_use_rs1),
        .id_use_rs2_i   (id_use_rs2),
        .id_reg_write_i (id_reg_write),
        .id_mem_read_i  (id_mem_read),
        .id_is_branch_i (id_is_branch),
        .pc_redirect_i  (pc_redirect),
        .pc_write_o     (pc_write),
        .if_id_write_o  (if_id_write),
        .control_src_o  (control_src),
        .id_ex_bubble_o (id_ex_bubble),
        .forward_a_o    (forward_a),
        .forward_b_o    (forward_b),
        .fwd_branch_a_o (fwd_branch_a),
`ifdef HAZ_PERF_CNT_EN
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt),
`endif
        .fwd_branch_b_o (fwd_branch_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1,
                         input logic u2, input logic wr,
                         input logic mr, input logic br);
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_rd        = rd;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_reg_write = wr;
        id_mem_read  = mr;
        id_is_branch = br;
    endtask

    task automatic nop();
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            nop();
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pc_redirect = 1'b0;
        drive(5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL rst_pc_write got %b want 1", pc_write); end
        checks++; if (if_id_write !== 1'b1) begin errors++; $display("FAIL rst_if_id got %b want 1", if_id_write); end
        checks++; if (id_ex_bubble !== 1'b1) begin errors++; $display("FAIL rst_bubble got %b want 1", id_ex_bubble); end
        checks++; if (control_src !== 1'b0) begin errors++; $display("FAIL rst_csrc got %b want 0", control_src); end
        checks++; if ({forward_a, forward_b} !== 4'b0) begin errors++; $display("FAIL rst_fwd got %b want 0000", {forward_a, forward_b}); end
        checks++; if ({fwd_branch_a, fwd_branch_b} !== 4'b0) begin errors++; $display("FAIL rst_fwdbr got %b want 0000", {fwd_branch_a, fwd_branch_b}); end
`ifdef HAZ_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
`endif
        #1;
        reset = 1'b1;
        nop();
        step();
        checks++; if (id_ex_bubble !== 1'b0) begin errors++; $display("FAIL rst_rel_bubble got %b want 0", id_ex_bubble); end
    endtask

    task automatic test_alu_fwd();
        drain();
        drive(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL alu_nostall got %b want 1", pc_write); end
        step();
        drive(5'd3, 5'd5, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (forward_a !== 2'b10) begin errors++; $display("FAIL alu_fa_mem got %b want 10", forward_a); end
        checks++; if (forward_b !== 2'b00) begin errors++; $display("FAIL alu_fb_none got %b want 00", forward_b); end
        step();
        drive(5'd5, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (forward_b !== 2'b01) begin errors++; $display("FAIL alu_fb_wb got %b want 01", forward_b); end
        checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL alu_fa_x3 got %b want 00", forward_a); end
        step();
        nop();
        #1;
        checks++; if (forward_a !== 2'b00) begin errors++; $display("FAIL alu_fa_far got %b want 00", forward_a); end
    endtask

    task automatic test_load_use();
        drain();
        drive(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive(5'd5, 5'd1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if ({pc_write, if_id_write, id_ex_bubble} !== 3'b001) begin errors++; $display("FAIL lu_stall got %b want 001", {pc_write, if_id_write, id_ex_bubble}); end
        step();
        checks++; if ({pc_write, id_ex_bubble} !== 2'b10) begin errors++; $display("FAIL lu_release got %b want 10", {pc_write, id_ex_bubble}); end
        step();
        nop();
        #1;
        checks++; if (forward_a !== 2'b01) begin errors++; $display("FAIL lu_fa_wb got %b want 01", forward_a); end
        drive(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive(5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lu_unused_rs2 got %b want 1", pc_write); end
    endtask

    task automatic test_load_branch();
        drain();
`ifdef HAZ_PERF_CNT_EN
        s0 = stall_cnt;
`endif
        drive(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive(5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        pc_redirect = 1'b1;
        #1;
        checks++; if ({pc_write, control_src} !== 2'b00) begin errors++; $display("FAIL lb_stall1 got %b want 00", {pc_write, control_src}); end
        step();
        pc_redirect = 1'b0;
        #1;
        checks++; if ({pc_write, id_ex_bubble} !== 2'b01) begin errors++; $display("FAIL lb_stall2 got %b want 01", {pc_write, id_ex_bubble}); end
        step();
        checks++; if ({pc_write, control_src} !== 2'b11) begin errors++; $display("FAIL lb_release got %b want 11", {pc_write, control_src}); end
        checks++; if (fwd_branch_a !== 2'b01) begin errors++; $display("FAIL lb_fba_wb got %b want 01", fwd_branch_a); end
        checks++; if (fwd_branch_b !== 2'b00) begin errors++; $display("FAIL lb_fbb_x0 got %b want 00", fwd_branch_b); end
`ifdef HAZ_PERF_CNT_EN
        checks++; if (stall_cnt !== s0 + 32'd2) begin errors++; $display("FAIL lb_stall_cnt got %0d want %0d", stall_cnt, s0 + 32'd2); end
`endif
        nop();
        step();
    endtask

    task automatic test_branch_fwd();
        drain();
`ifdef HAZ_PERF_CNT_EN
        f0 = flush_cnt;
`endif
        drive(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if ({fwd_branch_a, fwd_branch_b} !== 4'b1111) begin errors++; $display("FAIL br_ex got %b want 1111", {fwd_branch_a, fwd_branch_b}); end
        checks++; if ({control_src, pc_write} !== 2'b11) begin errors++; $display("FAIL br_csrc got %b want 11", {control_src, pc_write}); end
        pc_redirect = 1'b1;
        step();
        pc_redirect = 1'b0;
        drive(5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if ({id_ex_bubble, control_src, pc_write, if_id_write} !== 4'b1011) begin errors++; $display("FAIL br_flush got %b want 1011", {id_ex_bubble, control_src, pc_write, if_id_write}); end
`ifdef HAZ_PERF_CNT_EN
        checks++; if (flush_cnt !== f0 + 32'd1) begin errors++; $display("FAIL br_flush_cnt got %0d want %0d", flush_cnt, f0 + 32'd1); end
`endif
        step();
        drive(5'd7, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if ({fwd_branch_a, control_src, id_ex_bubble} !== 4'b0110) begin errors++; $display("FAIL br_wb got %b want 0110", {fwd_branch_a, control_src, id_ex_bubble}); end
        step();
        drive(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        nop();
        step();
        drive(5'd7, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (fwd_branch_a !== 2'b10) begin errors++; $display("FAIL br_mem got %b want 10", fwd_branch_a); end
        step();
        nop();
    endtask

    task automatic test_x0();
        drain();
        drive(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        checks++; if ({forward_a, forward_b} !== 4'b0000) begin errors++; $display("FAIL x0_fwd got %b want 0000", {forward_a, forward_b}); end
        step();
        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL x0_nostall got %b want 1", pc_write); end
        checks++; if ({fwd_branch_a, fwd_branch_b, forward_a} !== 6'b0) begin errors++; $display("FAIL x0_br got %b want 000000", {fwd_branch_a, fwd_branch_b, forward_a}); end
        step();
        nop();
    endtask

    task automatic test_reset_mid_stall();
        drain();
        drive(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        drive(5'd5, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL rms_stall got %b want 0", pc_write); end
        reset = 1'b0;
        #1;
        checks++; if ({pc_write, if_id_write, id_ex_bubble, control_src} !== 4'b1110) begin errors++; $display("FAIL rms_ctrl got %b want 1110", {pc_write, if_id_write, id_ex_bubble, control_src}); end
        checks++; if ({fwd_branch_a, fwd_branch_b} !== 4'b0000) begin errors++; $display("FAIL rms_fwd got %b want 0000", {fwd_branch_a, fwd_branch_b}); end
`ifdef HAZ_PERF_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rms_stall_cnt got %0d want 0", stall_cnt); end
`endif
        #1;
        reset = 1'b1;
        nop();
        step();
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_load_branch();
        test_branch_fwd();
        test_x0();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
